// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: NUM_CH requesters share one MEM_SIZE x MEM_WIDTH word
// array through a round-robin arbiter. One access per clock. The grant is
// combinational and the access commits at the grant edge. Read data,
// read-valid and error pulses are registered one cycle after the grant.
// Optional feature: define WSTRB_EN to add per-byte write strobes (ch_wstrb).
module mem_arbiter_ctrl #(
   parameter int MEM_WIDTH  = 32,
   parameter int MEM_SIZE   = 256,
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]  ch_addr,
   input  logic [NUM_CH-1:0]             ch_read_en,
   input  logic [NUM_CH-1:0]             ch_write_en,
   input  logic [NUM_CH*MEM_WIDTH-1:0]   ch_data_write,
`ifdef WSTRB_EN
   input  logic [NUM_CH*(MEM_WIDTH/8)-1:0] ch_wstrb,
`endif
   output logic [NUM_CH-1:0]             ch_grant,
   output logic [NUM_CH-1:0]             ch_read_valid,
   output logic [MEM_WIDTH-1:0]          data_read,
   output logic [NUM_CH-1:0]             ch_err
);

   localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NB   = MEM_WIDTH / 8;
   // One extra bit so MEM_SIZE itself is representable for the range check.
   localparam logic [ADDR_WIDTH:0] SIZE_EXT = MEM_SIZE[ADDR_WIDTH:0];

   logic [MEM_WIDTH-1:0]  mem [MEM_SIZE];

   logic [RR_W-1:0]       rr_q, rr_d;
   logic [NUM_CH-1:0]     rvalid_q, rvalid_d;
   logic [NUM_CH-1:0]     err_q, err_d;
   logic [MEM_WIDTH-1:0]  rdata_q, rdata_d;

   logic [NUM_CH-1:0]     req;
   logic                  gnt_found;
   logic [RR_W-1:0]       gnt_idx;
   int                    scan_idx;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [MEM_WIDTH-1:0]  sel_data;
   logic [NB-1:0]         sel_strb;
   logic                  illegal;
   logic                  do_rd;
   logic                  do_wr;

   assign req = ch_read_en | ch_write_en;

   // Round-robin scan starting at rr; grant is suppressed while in reset.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_idx = int'(rr_q) + k;
         if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
         if (!gnt_found && req[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = RR_W'(scan_idx);
         end
      end
      gnt_found = gnt_found & rst_n;
   end

   // Decode the granted channel's request and form the next register state.
   always_comb begin
      ch_grant = '0;
      rvalid_d = '0;
      err_d    = '0;
      rr_d     = rr_q;
      sel_addr = ch_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      sel_data = ch_data_write[int'(gnt_idx)*MEM_WIDTH +: MEM_WIDTH];
`ifdef WSTRB_EN
      sel_strb = ch_wstrb[int'(gnt_idx)*NB +: NB];
`else
      sel_strb = '1;
`endif
      illegal  = (ch_read_en[gnt_idx] & ch_write_en[gnt_idx]) |
                 ({1'b0, sel_addr} >= SIZE_EXT);
      do_rd    = gnt_found & ch_read_en[gnt_idx] & ~illegal;
      do_wr    = gnt_found & ch_write_en[gnt_idx] & ~illegal;
      rdata_d  = rdata_q;
      if (gnt_found) begin
         ch_grant[gnt_idx] = 1'b1;
         err_d[gnt_idx]    = illegal;
         if (int'(gnt_idx) == NUM_CH - 1) rr_d = '0;
         else                             rr_d = gnt_idx + 1'b1;
      end
      if (do_rd) begin
         rvalid_d[gnt_idx] = 1'b1;
         rdata_d           = mem[sel_addr];
      end
   end

   // Control and read-data registers; an in-flight read is dropped by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q     <= '0;
         rvalid_q <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         rr_q     <= rr_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage array write port, byte-granular when strobes are present.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; its contents survive rst_n and start undefined.
      if (do_wr) begin
         for (int b = 0; b < NB; b++) begin
            if (sel_strb[b]) mem[sel_addr][b*8 +: 8] <= sel_data[b*8 +: 8];
         end
      end
   end

   assign ch_read_valid = rvalid_q;
   assign ch_err        = err_q;
   assign data_read     = rdata_q;

endmodule
